// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control types for the five-stage core
package core_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_e;
  localparam int IDEX_CTRL_W = 7;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and pipeline-control outputs of the sequencing controller
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] ifid_rs1_i;
  logic [4:0] ifid_rs2_i;
  logic ifid_uses_rs2_i;
  logic idex_memread_i;
  logic [4:0] idex_rd_i;
  logic branch_taken_i;
  logic mem_req_i;
  logic mem_ready_i;
  logic pc_write_o;
  logic ifid_write_o;
  logic ifid_flush_o;
  logic idex_bubble_o;
  logic pipe_hold_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic mem_err_o;
  modport master (
    output ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i, idex_memread_i, idex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           stall_cnt_o, flush_cnt_o, mem_err_o
  );
  modport slave (
    input  ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i, idex_memread_i, idex_rd_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           stall_cnt_o, flush_cnt_o, mem_err_o
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr wins over inc
module sat_counter #(parameter int W = 16) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: arbitrates memory wait, taken-branch flush and load-use stall
// into PC / IF/ID / ID/EX enables, with stall/flush statistics and a timeout flag.
module hazard_ctrl import core_pkg::*; #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  hazard_ctrl_if.slave bus
);
  localparam logic [1:0]  FCNT_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic mem_err_q, mem_err_d;
  logic [15:0] wcnt;
  logic memwait, load_use, hold, br_evt, pc_w, ifid_w, flush, bubble;
  always_comb begin
    memwait = bus.mem_req_i & ~bus.mem_ready_i;
    load_use = bus.idex_memread_i & (bus.idex_rd_i != 5'd0) &
               ((bus.idex_rd_i == bus.ifid_rs1_i) |
                (bus.ifid_uses_rs2_i & (bus.idex_rd_i == bus.ifid_rs2_i)));
    // once waiting, only ready releases the hold
    hold = (state_q == MEM_WAIT) ? ~bus.mem_ready_i : memwait;
    br_evt = ~hold & (state_q != FLUSH) & bus.branch_taken_i;
    pc_w = 1'b1;
    ifid_w = 1'b1;
    flush = 1'b0;
    bubble = 1'b0;
    state_d = state_q;
    fcnt_d = fcnt_q;
    if (hold) begin
      pc_w = 1'b0;
      ifid_w = 1'b0;
      state_d = (state_q == FLUSH) ? FLUSH : MEM_WAIT;
    end else if (state_q == FLUSH) begin
      flush = 1'b1;
      bubble = 1'b1;
      fcnt_d = fcnt_q - 2'd1;
      state_d = (fcnt_q == 2'd1) ? RUN : FLUSH;
    end else if (br_evt) begin
      flush = 1'b1;
      bubble = 1'b1;
      fcnt_d = FCNT_INIT;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      state_d = RUN;
      pc_w = ~load_use;
      ifid_w = ~load_use;
      bubble = load_use;
    end
    mem_err_d = mem_err_q | (hold & (wcnt == WAIT_LAST));
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= RUN;
      fcnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      mem_err_q <= mem_err_d;
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk_i, .rst_i, .inc(~pc_w), .clr(1'b0), .q(bus.stall_cnt_o));
  sat_counter #(.W(CNT_W)) u_flush (.clk_i, .rst_i, .inc(br_evt), .clr(1'b0), .q(bus.flush_cnt_o));
  sat_counter #(.W(16)) u_wait (.clk_i, .rst_i, .inc(hold), .clr(~hold), .q(wcnt));
  // reset forces a safe pipeline picture without waiting for a clock
  assign bus.pc_write_o = rst_i & pc_w;
  assign bus.ifid_write_o = rst_i & ifid_w;
  assign bus.pipe_hold_o = rst_i & hold;
  assign bus.ifid_flush_o = ~rst_i | flush;
  assign bus.idex_bubble_o = ~rst_i | bubble;
  assign bus.mem_err_o = mem_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, hand-written corner sequences and a randomized
// run against a cycle-level behavioural model of the hazard controller.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [4:0] O_DEF = 5'b11000, O_LU = 5'b00010, O_BR = 5'b11110,
                         O_HOLD = 5'b00001, O_RST = 5'b00110;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  hazard_ctrl_if #(.CNT_W(CW)) bus ();
  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic mr; logic [4:0] rd, rs1, rs2; logic u2, br, req, rdy; logic [4:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [4:0] exp);
    chk(nm, {27'd0, bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
             bus.idex_bubble_o, bus.pipe_hold_o}, {27'd0, exp});
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, rs1, rs2,
                       input logic u2, br, req, rdy);
    bus.idex_memread_i = mr;
    bus.idex_rd_i = rd;
    bus.ifid_rs1_i = rs1;
    bus.ifid_rs2_i = rs2;
    bus.ifid_uses_rs2_i = u2;
    bus.branch_taken_i = br;
    bus.mem_req_i = req;
    bus.mem_ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic step(input string nm, input logic [4:0] exp);
    #2;
    chk_outs(nm, exp);
    tick();
  endtask

  // behavioural model state for the random run
  int stall_m, flush_m, wait_m, fleft;
  logic err_m, in_wait;

  task automatic random_run(input int n);
    logic hz, lu;
    logic [4:0] e;
    stall_m = 0; flush_m = 0; wait_m = 0; fleft = 0; err_m = 0; in_wait = 0;
    for (int c = 0; c < n; c++) begin
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
            in_wait ? 1'b1 : $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      hz = bus.mem_req_i & ~bus.mem_ready_i;
      lu = bus.idex_memread_i && bus.idex_rd_i != 0 && (bus.idex_rd_i == bus.ifid_rs1_i ||
           (bus.ifid_uses_rs2_i && bus.idex_rd_i == bus.ifid_rs2_i));
      if (hz) e = O_HOLD;
      else if (fleft > 0 || bus.branch_taken_i) e = O_BR;
      else if (lu) e = O_LU;
      else e = O_DEF;
      #2;
      chk_outs("rnd_outs", e);
      chk("rnd_stall", 32'(bus.stall_cnt_o), 32'(stall_m));
      chk("rnd_flush", 32'(bus.flush_cnt_o), 32'(flush_m));
      chk("rnd_err", 32'(bus.mem_err_o), 32'(err_m));
      if (!e[4]) stall_m = (stall_m < SAT) ? stall_m + 1 : SAT;
      if (hz) begin
        wait_m++;
        if (wait_m >= MT) err_m = 1'b1;
      end else begin
        wait_m = 0;
        if (fleft > 0) fleft--;
        else if (bus.branch_taken_i) begin
          flush_m = (flush_m < SAT) ? flush_m + 1 : SAT;
          fleft = FC - 1;
        end
      end
      in_wait = hz;
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_outs("reset_outs", O_RST);
    chk("reset_cnts", {bus.stall_cnt_o, bus.flush_cnt_o, 23'd0, bus.mem_err_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    //           mr  rd  rs1 rs2 u2 br req rdy exp
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, O_DEF};
    tbl[1]  = '{1, 5, 5, 0, 0, 0, 0, 0, O_LU};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, O_DEF};
    tbl[3]  = '{1, 7, 3, 7, 0, 0, 0, 0, O_DEF};
    tbl[4]  = '{1, 7, 3, 7, 1, 0, 0, 0, O_LU};
    tbl[5]  = '{0, 5, 5, 5, 1, 0, 0, 0, O_DEF};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, O_BR};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, O_HOLD};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, O_DEF};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 0, O_HOLD};
    tbl[10] = '{1, 5, 5, 0, 0, 1, 0, 0, O_BR};
    tbl[11] = '{1, 5, 5, 0, 0, 0, 1, 0, O_HOLD};
    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u2, tbl[i].br,
            tbl[i].req, tbl[i].rdy);
      step($sformatf("vec%0d", i), tbl[i].exp);
    end
    // load-use lasts one cycle
    do_reset();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    step("lu_c0", O_LU);
    drive(0, 5, 5, 0, 0, 0, 0, 0);
    step("lu_c1", O_DEF);
    chk("lu_stall", 32'(bus.stall_cnt_o), 1);
    // taken branch: FC bubble cycles
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step("br_c0", O_BR);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step("br_c1", O_BR);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("br_c2", O_DEF);
    chk("br_flush", 32'(bus.flush_cnt_o), 1);
    // three-cycle memory wait, released in the ready cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      step("mw_hold", O_HOLD);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step("mw_rel", O_DEF);
    chk("mw_stall", 32'(bus.stall_cnt_o), 3);
    // memwait and branch together: hold first, flush from the release cycle
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      step("mb_hold", O_HOLD);
    end
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    step("mb_rel", O_BR);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("mb_fl2", O_BR);
    step("mb_done", O_DEF);
    chk("mb_flush", 32'(bus.flush_cnt_o), 1);
    chk("mb_stall", 32'(bus.stall_cnt_o), 2);
    // timeout after MT wait cycles, sticky afterwards
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      #2;
      chk("to_err", 32'(bus.mem_err_o), (i >= MT) ? 1 : 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step("to_rel", O_DEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("to_sticky", 32'(bus.mem_err_o), 1);
    // asynchronous reset while waiting
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("ar_hold", O_HOLD);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("ar_outs", O_RST);
    chk("ar_cnts", {bus.stall_cnt_o, bus.flush_cnt_o, 23'd0, bus.mem_err_o}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk_outs("ar_run", O_DEF);
    tick();
    chk("ar_stall", 32'(bus.stall_cnt_o), 0);
    // stall counter saturation
    do_reset();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(bus.stall_cnt_o), SAT);
    do_reset();
    random_run(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It drives the write-enable, flush and bubble controls of the PC, the IF/ID register and the ID/EX register, and the hold control of the later stage registers. It arbitrates three hazard sources by fixed priority:

- data-memory wait
- taken-branch flush
- load-use stall

It also keeps saturating stall and flush statistics and a sticky memory-timeout error flag.

## Interface

Parameters:

- FLUSH_CYCLES, 1 — bubble cycles per taken branch; legal range 1–3.
- MEM_TIMEOUT, 255 — MEM_WAIT cycles before mem_err_o sets; legal range 1–65535.
- CNT_W, 16 — width of the statistics counters.

Ports:

- clk_i  in  1  — clock; all state updates on the rising edge.
- rst_i  in  1  — reset; asynchronous, active-low.
- ifid_rs1_i  in  5  — rs1 field of the instruction in IF/ID.
- ifid_rs2_i  in  5  — rs2 field of the instruction in IF/ID.
- ifid_uses_rs2_i  in  1  — the IF/ID instruction reads rs2.
- idex_memread_i  in  1  — MemRead control bit currently in ID/EX.
- idex_rd_i  in  5  — rd field currently in ID/EX.
- branch_taken_i  in  1  — branch resolved taken in EX this cycle.
- mem_req_i  in  1  — EX/MEM holds a load or store.
- mem_ready_i  in  1  — data memory completes the access this cycle.
- pc_write_o  out  1  — PC register enable.
- ifid_write_o  out  1  — IF/ID register enable.
- ifid_flush_o  out  1  — IF/ID loads a NOP.
- idex_bubble_o  out  1  — ID/EX control bits (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc) load zero.
- pipe_hold_o  out  1  — ID/EX, EX/MEM and MEM/WB hold their contents.
- stall_cnt_o  out  CNT_W  — count of cycles with pc_write_o=0; saturating.
- flush_cnt_o  out  CNT_W  — count of taken-branch events; saturating.
- mem_err_o  out  1  — sticky memory-timeout flag.

## Operation

The FSM has three states: RUN, MEM_WAIT and FLUSH. Outputs are Mealy, combinational from the state and the inputs. Counters and flags are registered.

Internal terms:

- memwait = mem_req_i & ~mem_ready_i
- load_use = idex_memread_i & (idex_rd_i != 0) & ((idex_rd_i == ifid_rs1_i) | (ifid_uses_rs2_i & idex_rd_i == ifid_rs2_i))

Default outputs: pc_write_o=1, ifid_write_o=1, all other control outputs 0.

RUN, evaluated in priority order:

- memwait: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0; next state MEM_WAIT.
- branch_taken_i: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1 (PC loads the target). flush_cnt_o increments. If FLUSH_CYCLES>1, next state FLUSH with fcnt=FLUSH_CYCLES-1.
- load_use: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; state stays RUN.

MEM_WAIT:

- While mem_ready_i=0: outputs as for memwait. wcnt increments. When wcnt reaches MEM_TIMEOUT, mem_err_o sets and the FSM keeps waiting.
- On the cycle mem_ready_i=1: outputs are evaluated as in RUN with memwait forced to 0, so release takes effect in the same cycle. Next state RUN; wcnt clears.

FLUSH:

- memwait has priority; its outputs are as in RUN, and fcnt is frozen.
- Otherwise: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, ifid_write_o=1. fcnt decrements; at fcnt=1 the next state is RUN.
- branch_taken_i is ignored, because EX holds only bubbles.

Arithmetic and sticky rules:

- stall_cnt_o and flush_cnt_o saturate at 2^CNT_W-1.
- mem_err_o clears only on reset.

## Timing

- Hazard response has zero latency: a condition present in cycle N affects the enables sampled at the edge ending cycle N.
- A load-use stall lasts exactly one cycle. In the next cycle idex_memread_i=0 because of the inserted bubble.
- Taken branch: FLUSH_CYCLES bubble cycles in total, starting in the cycle where branch_taken_i=1.
- Memory wait: one hold cycle per cycle with mem_ready_i=0; zero hold cycles if ready arrives with the request.
- Simultaneous memwait and branch_taken_i: the hold wins. branch_taken_i stays asserted, because EX is frozen, and the branch is served after release.
- While rst_i=0, regardless of the clock:
  - pc_write_o=0, ifid_write_o=0, pipe_hold_o=0
  - ifid_flush_o=1, idex_bubble_o=1
  - stall_cnt_o=0, flush_cnt_o=0, mem_err_o=0
  - state RUN, fcnt=0, wcnt=0
- Deasserting rst_i in the middle of a wait or flush leaves no residual FLUSH or MEM_WAIT state.

## Structure

- The shared package core_pkg holds the state enumeration (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2) and the control-bit-vector width of ID/EX.
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr; saturating). It is instantiated for stall_cnt_o, flush_cnt_o and wcnt.
- The load_use comparator stays inline.

## Test plan

- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5 for one cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly 1 cycle; stall_cnt_o=1.
- rd=x0 and rs2-unused cases:
  - idex_rd_i=0, rs1=0 -> no stall.
  - rs2 match with ifid_uses_rs2_i=0 -> no stall.
- Branch with FLUSH_CYCLES=2: branch_taken_i pulse -> ifid_flush_o=idex_bubble_o=1 for 2 cycles; flush_cnt_o=1.
- Memory wait: mem_req_i=1, mem_ready_i low for 3 cycles -> pipe_hold_o=1 for 3 cycles and drops in the cycle mem_ready_i=1; stall_cnt_o=3.
- Simultaneous memwait and branch_taken_i -> hold first; flush starts in the release cycle. Timeout with MEM_TIMEOUT=4 and 6 wait cycles -> mem_err_o=1 and stays 1 afterward.
- Reset asserted in MEM_WAIT -> outputs take their reset values immediately without a clock edge; after release the state is RUN and the counters read 0.
